// File: rtl/pull_responder_fifo_pkg.sv
// Shared defaults and sizing helpers for the pull responder FIFO.
package pull_responder_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 8;

    // Occupancy needs one extra bit so that "full" (level == depth) is representable.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pull_resp_fifo_mem.sv
// Storage array, pointers and occupancy for the pull responder FIFO.
module pull_resp_fifo_mem
    import pull_responder_fifo_pkg::*;
#(
    parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
    parameter int unsigned depth      = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [data_width-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [data_width-1:0]         rd_data_c,
    output logic [level_width(depth)-1:0] level,
    output logic                          full_c,
    output logic                          empty_c
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned LVL_W = level_width(depth);

    logic [data_width-1:0] mem [depth];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    assign rd_data_c = mem[rd_ptr];
    assign full_c    = (level == LVL_W'(depth));
    assign empty_c   = (level == '0);

    // Contents are deliberately not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pull_responder_fifo.sv
// Responder end of the req/ack pull protocol: buffers pushed words and serves
// each one as a single-cycle ack pulse with data held on dout until the next ack.
module pull_responder_fifo
    import pull_responder_fifo_pkg::*;
#(
    parameter int unsigned              data_width    = DEFAULT_DATA_WIDTH,
    parameter int unsigned              depth         = DEFAULT_DEPTH,
    parameter logic [data_width-1:0]    initial_value = '0,
    parameter int unsigned              count_width   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [data_width-1:0]         in_data,
    input  logic                          req,
    output logic                          ack,
    output logic [data_width-1:0]         dout,
    output logic [level_width(depth)-1:0] level,
    output logic [count_width-1:0]        count
);

    logic                  wr_en_c;
    logic                  serve_c;
    logic                  full_c;
    logic                  empty_c;
    logic [data_width-1:0] rd_data_c;

    // No read bypass: a slot freed by this cycle's serve is offered next cycle.
    assign in_ready = ~rst & ~full_c;
    assign wr_en_c  = in_valid & in_ready;
    // Suppressing a serve while ack is high keeps acks at most every other cycle.
    assign serve_c  = req & ~ack & ~empty_c;

    pull_resp_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_c),
        .wr_data   (in_data),
        .rd_en     (serve_c),
        .rd_data_c (rd_data_c),
        .level     (level),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            dout  <= initial_value;
            count <= '0;
        end else begin
            ack <= serve_c;
            if (serve_c) begin
                dout  <= rd_data_c;
                count <= count + count_width'(1);
            end
        end
    end

endmodule
